// File: rtl/csr_pkg.sv
// Shared machine-mode CSR types and bit positions for the trap sequencer and CSR file.
package csr_pkg;

    localparam int CSR_XLEN = 64;

    typedef struct packed {
        logic [CSR_XLEN-1:0] mstatus;
        logic [CSR_XLEN-1:0] mie;
        logic [CSR_XLEN-1:0] mip;
        logic [CSR_XLEN-1:0] mtvec;
        logic [CSR_XLEN-1:0] mepc;
        logic [CSR_XLEN-1:0] mcause;
        logic [CSR_XLEN-1:0] mtval;
        logic [CSR_XLEN-1:0] mcycle;
    } csr_pack;

    typedef struct packed {
        logic mstatus;
        logic mie;
        logic mip;
        logic mtvec;
        logic mepc;
        logic mcause;
        logic mtval;
        logic mcycle;
    } csr_mask;

    typedef enum logic [1:0] {
        TRAP_IDLE     = 2'd0,
        TRAP_DRAIN    = 2'd1,
        TRAP_WRITE    = 2'd2,
        TRAP_REDIRECT = 2'd3
    } trap_state_t;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;

    localparam int IRQ_MEI = 11;
    localparam int IRQ_MSI = 3;
    localparam int IRQ_MTI = 7;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Two-flop synchronizer for asynchronous interrupt lines, cleared by reset.
module irq_sync #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes exceptions, mret and interrupts, drains the
// pipeline, applies one masked CSR write and redirects fetch.
//   state    | meaning
//   IDLE     | waiting for an event; owns mip updates
//   DRAIN    | drain_req high until the pipeline is empty
//   WRITE    | single masked CSR write; redirect target latched
//   REDIRECT | redirect_valid high until fetch accepts
module trap_ctrl
    import csr_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  csr_pack         csrs,
    output csr_pack         new_csrs,
    output csr_mask         mask,
    input  logic            exc_valid,
    input  logic [XLEN-1:0] exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] next_pc,
    input  logic            meip,
    input  logic            mtip,
    input  logic            msip,
    output logic            drain_req,
    input  logic            drain_ack,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            busy
);

    localparam logic [1:0] S_IDLE     = TRAP_IDLE;
    localparam logic [1:0] S_DRAIN    = TRAP_DRAIN;
    localparam logic [1:0] S_WRITE    = TRAP_WRITE;
    localparam logic [1:0] S_REDIRECT = TRAP_REDIRECT;

    logic [1:0]      state_d, state_q;
    logic            mret_d, mret_q;
    logic            irq_d, irq_q;
    logic [XLEN-1:0] cause_d, cause_q;
    logic [XLEN-1:0] epc_d, epc_q;
    logic [XLEN-1:0] tval_d, tval_q;
    logic [XLEN-1:0] redir_d, redir_q;

    // sync_irq bit order: [2]=MEI, [1]=MTI, [0]=MSI
    logic [2:0] sync_irq;
    logic       pend_mei, pend_msi, pend_mti, irq_take;
    logic [XLEN-1:0] vec_base;

    irq_sync #(.WIDTH(3)) u_irq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({meip, mtip, msip}),
        .q     (sync_irq)
    );

    always_comb begin
        pend_mei = csrs.mip[IRQ_MEI] & csrs.mie[IRQ_MEI];
        pend_msi = csrs.mip[IRQ_MSI] & csrs.mie[IRQ_MSI];
        pend_mti = csrs.mip[IRQ_MTI] & csrs.mie[IRQ_MTI];
        irq_take = csrs.mstatus[MSTATUS_MIE_BIT] & (pend_mei | pend_msi | pend_mti);
        vec_base = {csrs.mtvec[XLEN-1:2], 2'b00};
    end

    always_comb begin
        state_d  = state_q;
        mret_d   = mret_q;
        irq_d    = irq_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        tval_d   = tval_q;
        redir_d  = redir_q;
        new_csrs = csrs;
        mask     = '0;

        case (state_q)
            S_IDLE: begin
                if ({sync_irq[2], sync_irq[1], sync_irq[0]} !=
                    {csrs.mip[IRQ_MEI], csrs.mip[IRQ_MTI], csrs.mip[IRQ_MSI]}) begin
                    mask.mip = 1'b1;
                    new_csrs.mip[IRQ_MEI] = sync_irq[2];
                    new_csrs.mip[IRQ_MTI] = sync_irq[1];
                    new_csrs.mip[IRQ_MSI] = sync_irq[0];
                end
                if (exc_valid) begin
                    state_d = S_DRAIN;
                    mret_d  = 1'b0;
                    irq_d   = 1'b0;
                    cause_d = exc_code;
                    epc_d   = exc_pc;
                    tval_d  = exc_tval;
                end else if (mret_valid) begin
                    state_d = S_DRAIN;
                    mret_d  = 1'b1;
                    irq_d   = 1'b0;
                end else if (irq_take) begin
                    state_d = S_DRAIN;
                    mret_d  = 1'b0;
                    irq_d   = 1'b1;
                    epc_d   = next_pc;
                    tval_d  = '0;
                    if (pend_mei)      cause_d = XLEN'(IRQ_MEI);
                    else if (pend_msi) cause_d = XLEN'(IRQ_MSI);
                    else               cause_d = XLEN'(IRQ_MTI);
                end
            end
            S_DRAIN: begin
                if (drain_ack) state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_REDIRECT;
                if (mret_q) begin
                    mask.mstatus = 1'b1;
                    new_csrs.mstatus[MSTATUS_MIE_BIT]       = csrs.mstatus[MSTATUS_MPIE_BIT];
                    new_csrs.mstatus[MSTATUS_MPIE_BIT]      = 1'b1;
                    new_csrs.mstatus[MSTATUS_MPP_LO +: 2]   = 2'b00;
                    redir_d = csrs.mepc;
                end else begin
                    mask.mstatus = 1'b1;
                    mask.mepc    = 1'b1;
                    mask.mcause  = 1'b1;
                    mask.mtval   = 1'b1;
                    new_csrs.mepc   = epc_q;
                    new_csrs.mcause = irq_q ? {1'b1, cause_q[XLEN-2:0]} : cause_q;
                    new_csrs.mtval  = irq_q ? '0 : tval_q;
                    new_csrs.mstatus[MSTATUS_MPIE_BIT]      = csrs.mstatus[MSTATUS_MIE_BIT];
                    new_csrs.mstatus[MSTATUS_MIE_BIT]       = 1'b0;
                    new_csrs.mstatus[MSTATUS_MPP_LO +: 2]   = 2'b11;
                    if (irq_q && csrs.mtvec[1:0] == MTVEC_MODE_VECTORED)
                        redir_d = vec_base + (cause_q << 2);
                    else
                        redir_d = vec_base;
                end
            end
            S_REDIRECT: begin
                if (redirect_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mret_q  <= 1'b0;
            irq_q   <= 1'b0;
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
            redir_q <= '0;
        end else begin
            state_q <= state_d;
            mret_q  <= mret_d;
            irq_q   <= irq_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
            redir_q <= redir_d;
        end
    end

    assign drain_req      = (state_q == S_DRAIN);
    assign redirect_valid = (state_q == S_REDIRECT);
    assign busy           = (state_q != S_IDLE);
    assign redirect_pc    = redir_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with a small masked-write CSR file around it.
module tb_trap_ctrl;
    import csr_pkg::*;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    csr_pack         csrs, new_csrs, sw_csrs;
    csr_mask         mask;
    logic            sw_we;
    logic            exc_valid, mret_valid;
    logic [XLEN-1:0] exc_code, exc_pc, exc_tval, next_pc;
    logic            meip, mtip, msip;
    logic            drain_req, drain_ack, redirect_valid, redirect_ready, busy;
    logic [XLEN-1:0] redirect_pc;
    logic [7:0]      mask_bits;

    int checks = 0;
    int failures = 0;

    localparam logic [7:0] M_TRAP = 8'h8E;   // mstatus|mepc|mcause|mtval
    localparam logic [7:0] M_MRET = 8'h80;
    localparam logic [7:0] M_MIP  = 8'h20;

    assign mask_bits = mask;

    trap_ctrl #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .csrs           (csrs),
        .new_csrs       (new_csrs),
        .mask           (mask),
        .exc_valid      (exc_valid),
        .exc_code       (exc_code),
        .exc_pc         (exc_pc),
        .exc_tval       (exc_tval),
        .mret_valid     (mret_valid),
        .next_pc        (next_pc),
        .meip           (meip),
        .mtip           (mtip),
        .msip           (msip),
        .drain_req      (drain_req),
        .drain_ack      (drain_ack),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // CSR file: software write wins, otherwise per-field masked update
    always_ff @(posedge clk) begin
        if (sw_we) begin
            csrs <= sw_csrs;
        end else begin
            if (mask.mstatus) csrs.mstatus <= new_csrs.mstatus;
            if (mask.mie)     csrs.mie     <= new_csrs.mie;
            if (mask.mip)     csrs.mip     <= new_csrs.mip;
            if (mask.mtvec)   csrs.mtvec   <= new_csrs.mtvec;
            if (mask.mepc)    csrs.mepc    <= new_csrs.mepc;
            if (mask.mcause)  csrs.mcause  <= new_csrs.mcause;
            if (mask.mtval)   csrs.mtval   <= new_csrs.mtval;
            if (mask.mcycle)  csrs.mcycle  <= new_csrs.mcycle;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sw_set(input csr_pack v);
        sw_csrs = v;
        sw_we   = 1'b1;
        tick();
        sw_we   = 1'b0;
    endtask

    task automatic raise_exc(input logic [63:0] code, input logic [63:0] pc, input logic [63:0] tval);
        exc_valid = 1'b1;
        exc_code  = code;
        exc_pc    = pc;
        exc_tval  = tval;
        tick();
        exc_valid = 1'b0;
    endtask

    task automatic finish_redirect();
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        csr_pack v;
        int bad;
        bit seen;

        rst_n = 1'b0;
        exc_valid = 0; mret_valid = 0; exc_code = '0; exc_pc = '0; exc_tval = '0;
        next_pc = '0; meip = 0; mtip = 0; msip = 0;
        drain_ack = 0; redirect_ready = 0;
        sw_csrs = '0; sw_we = 1'b1;
        repeat (3) tick();
        check("rst_drain_req", 64'(drain_req), 64'd0);
        check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_redirect_pc", redirect_pc, 64'd0);
        check("rst_mask", 64'(mask_bits), 64'd0);
        sw_we = 1'b0;
        rst_n = 1'b1;
        tick();

        // exception, direct vector, drain_ack already high
        v = '0; v.mtvec = 64'h8000_0000; v.mstatus = 64'h8;
        sw_set(v);
        drain_ack = 1'b1;
        raise_exc(64'd2, 64'h100, 64'hDEAD);
        check("exc_drain_req", 64'(drain_req), 64'd1);
        check("exc_busy", 64'(busy), 64'd1);
        tick();
        check("exc_write_mask", 64'(mask_bits), 64'(M_TRAP));
        tick();
        check("exc_redirect_valid", 64'(redirect_valid), 64'd1);
        check("exc_redirect_pc", redirect_pc, 64'h8000_0000);
        check("exc_mepc", csrs.mepc, 64'h100);
        check("exc_mcause", csrs.mcause, 64'd2);
        check("exc_mtval", csrs.mtval, 64'hDEAD);
        check("exc_mstatus", csrs.mstatus, 64'h1880);
        check("exc_redirect_mask", 64'(mask_bits), 64'd0);
        finish_redirect();
        check("exc_idle", 64'(busy), 64'd0);

        // timer interrupt, vectored mode
        v = '0; v.mtvec = 64'h8000_0001; v.mstatus = 64'h8; v.mie = 64'h80; v.mtval = 64'h5555;
        sw_set(v);
        mtip = 1'b1; next_pc = 64'h200;
        tick(); tick();
        check("mtip_mask_mip", 64'(mask_bits), 64'(M_MIP));
        check("mtip_mip_before", csrs.mip, 64'd0);
        tick();
        check("mtip_mip_visible", csrs.mip, 64'h80);
        check("mtip_still_idle", 64'(busy), 64'd0);
        tick();
        check("mtip_drain", 64'(drain_req), 64'd1);
        tick();
        check("mtip_new_mcause", new_csrs.mcause, 64'h8000_0000_0000_0007);
        tick();
        check("mtip_redirect_pc", redirect_pc, 64'h8000_001C);
        check("mtip_mepc", csrs.mepc, 64'h200);
        check("mtip_mtval", csrs.mtval, 64'd0);
        check("mtip_mstatus", csrs.mstatus, 64'h1880);
        mtip = 1'b0;
        finish_redirect();
        repeat (4) tick();
        check("mtip_mip_cleared", csrs.mip, 64'd0);
        check("mtip_no_reentry", 64'(busy), 64'd0);

        // all three pending: MEI wins; no re-entry while MIE is clear
        v = '0; v.mtvec = 64'h8000_0000; v.mstatus = 64'h8; v.mie = 64'h888;
        sw_set(v);
        meip = 1'b1; msip = 1'b1; mtip = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("all_irq_taken", 64'(seen), 64'd1);
        tick();
        check("all_irq_mcause", new_csrs.mcause, 64'h8000_0000_0000_000B);
        check("all_irq_mask", 64'(mask_bits), 64'(M_TRAP));
        tick();
        check("all_irq_redirect_pc", redirect_pc, 64'h8000_0000);
        finish_redirect();
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) bad++;
            tick();
        end
        check("all_irq_no_reentry", 64'(bad), 64'd0);
        meip = 1'b0; msip = 1'b0; mtip = 1'b0;
        repeat (5) tick();

        // mret
        v = '0; v.mtvec = 64'h8000_0000; v.mstatus = 64'h1880; v.mepc = 64'h300;
        sw_set(v);
        mret_valid = 1'b1;
        tick();
        mret_valid = 1'b0;
        check("mret_drain", 64'(drain_req), 64'd1);
        tick();
        check("mret_mask", 64'(mask_bits), 64'(M_MRET));
        check("mret_new_mstatus", new_csrs.mstatus, 64'h88);
        tick();
        check("mret_redirect_pc", redirect_pc, 64'h300);
        check("mret_mstatus", csrs.mstatus, 64'h88);
        finish_redirect();

        // stalls in DRAIN and REDIRECT; exception under vectored mtvec uses base
        v = '0; v.mtvec = 64'h8000_0001;
        sw_set(v);
        drain_ack = 1'b0;
        raise_exc(64'd5, 64'h400, 64'h44);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!(drain_req && busy)) bad++;
            tick();
        end
        check("stall_drain", 64'(bad), 64'd0);
        drain_ack = 1'b1;
        tick();
        tick();
        check("stall_redirect_pc", redirect_pc, 64'h8000_0000);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (!(redirect_valid && busy && redirect_pc == 64'h8000_0000)) bad++;
            tick();
        end
        check("stall_redirect_hold", 64'(bad), 64'd0);
        check("stall_mstatus", csrs.mstatus, 64'h1800);
        finish_redirect();
        check("stall_idle", 64'(busy), 64'd0);

        // reset during DRAIN
        drain_ack = 1'b0;
        raise_exc(64'd7, 64'h500, 64'h77);
        check("rstd_in_drain", 64'(drain_req), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstd_busy", 64'(busy), 64'd0);
        check("rstd_drain_req", 64'(drain_req), 64'd0);
        check("rstd_redirect_valid", 64'(redirect_valid), 64'd0);
        check("rstd_redirect_pc", redirect_pc, 64'd0);
        check("rstd_mask", 64'(mask_bits), 64'd0);
        tick();
        rst_n = 1'b1;
        check("rstd_mepc_untouched", csrs.mepc, 64'h400);
        drain_ack = 1'b1;
        v = '0; v.mtvec = 64'h8000_0000;
        sw_set(v);
        raise_exc(64'd1, 64'h600, 64'h66);
        tick();
        tick();
        check("rstd_after_mepc", csrs.mepc, 64'h600);
        check("rstd_after_mcause", csrs.mcause, 64'd1);
        check("rstd_after_redirect_pc", redirect_pc, 64'h8000_0000);
        finish_redirect();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer that owns every non-software write to the CSR file. It accepts exception and mret requests from the commit stage and arbitrates the three machine interrupt lines. On each event it drains the pipeline, applies the CSR updates in one masked write cycle, and issues a fetch redirect. It sits between commit/fetch and the CSR file, driving that file's `new_csrs`/`mask` inputs; the software CSR-instruction path is muxed in upstream only while `busy` is low.

## Interface
Parameters:
- `XLEN`, 64, CSR and PC width

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `csrs`  in  csr_pack  current CSR values
- `new_csrs`  out  csr_pack  CSR write data
- `mask`  out  csr_mask  per-CSR write enables
- `exc_valid`  in  1  commit-stage exception; single-cycle pulse
- `exc_code`  in  XLEN  exception cause code (bit XLEN-1 is 0)
- `exc_pc`  in  XLEN  PC of the faulting instruction
- `exc_tval`  in  XLEN  trap value
- `mret_valid`  in  1  mret committed; single-cycle pulse
- `next_pc`  in  XLEN  PC of the next instruction to commit; becomes mepc for interrupts
- `meip`, `mtip`, `msip`  in  1 each  asynchronous interrupt lines
- `drain_req`  out  1  request pipeline quiesce
- `drain_ack`  in  1  pipeline empty, no memory access in flight
- `redirect_valid`  out  1  fetch redirect valid
- `redirect_pc`  out  XLEN  redirect target
- `redirect_ready`  in  1  fetch accepts the redirect
- `busy`  out  1  high in any state other than IDLE; commit stalls while high

## Operation
- FSM states: IDLE, DRAIN, WRITE, REDIRECT.
- IDLE:
  - Event priority is exc_valid > mret_valid > interrupt.
  - An interrupt is taken when `csrs.mstatus[3]` (MIE) is 1 and `(csrs.mip & csrs.mie)` has any of bits 11/7/3 set.
  - Interrupt priority: MEI (11) > MSI (3) > MTI (7).
  - When an event is taken, the controller latches the kind (TRAP/MRET), cause, epc and tval, then moves to DRAIN.
- DRAIN: `drain_req`=1. On `drain_ack`, go to WRITE.
- WRITE: one cycle only, then REDIRECT.
  - TRAP writes:
    - mepc = latched pc.
    - mcause = code, with bit XLEN-1 set for interrupts.
    - mtval = tval for exceptions, 0 for interrupts.
    - mstatus: MPIE(7) ← MIE, MIE(3) ← 0, MPP(12:11) ← 2'b11.
    - `mask.mepc`, `mask.mcause`, `mask.mtval` and `mask.mstatus` are high.
  - MRET writes mstatus only: MIE ← MPIE, MPIE ← 1, MPP ← 2'b00.
  - All other mask bits are 0. `mcycle` is never written.
  - The redirect target is latched in this cycle:
    - MRET: `csrs.mepc`.
    - TRAP, `mtvec[1:0]`==0 (direct), or exception: `{mtvec[XLEN-1:2],2'b00}`.
    - TRAP, `mtvec[1:0]`==1 (vectored) and interrupt: base + 4×code.
- REDIRECT: `redirect_valid`=1 and `redirect_pc` is held stable until `redirect_ready`; then return to IDLE.
- mip ownership: each interrupt line passes through a two-flop synchronizer.
  - In IDLE, when the synchronized bits differ from `csrs.mip[11,7,3]`, assert `mask.mip` for one cycle.
  - `new_csrs.mip` is `csrs.mip` with those bits replaced.
  - In all other states, the mip update waits.
- `new_csrs` fields whose mask bit is 0 carry `csrs` values.
- `exc_valid`/`mret_valid` arriving outside IDLE are ignored. Upstream guarantees none arrive while `busy`=1.

## Timing
- Reset: state IDLE; `drain_req`, `redirect_valid`, `busy` and all mask bits = 0; `redirect_pc` = 0; latches and synchronizers = 0.
- All outputs are Moore (decoded from state/latches), except `new_csrs`/`mask`, which are combinational from state, latches and `csrs`.
- Event sampled in IDLE at cycle 0:
  - DRAIN at cycle 1.
  - With `drain_ack` already high: WRITE at cycle 2, new CSR values visible at cycle 3, `redirect_valid` at cycle 3.
  - Minimum redirect latency is 3 cycles.
- Interrupt line edge to visible in `csrs.mip`: 3 cycles (2 sync + 1 write) when IDLE.
- Interrupt pending at the same cycle as exc_valid: the exception is taken. The interrupt is re-evaluated in IDLE after the redirect completes.
- Reset asserted in any state: immediate return to IDLE with all outputs at reset values. No partial CSR write occurs, because the write is a single cycle.

## Structure
- Add to `csr_pkg`:
  - `trap_state_t` enum.
  - Constants `MSTATUS_MIE_BIT`=3, `MSTATUS_MPIE_BIT`=7, `MSTATUS_MPP_LO`=11.
  - Constants `IRQ_MEI`=11, `IRQ_MSI`=3, `IRQ_MTI`=7.
  - `MTVEC_MODE_VECTORED`=1.
- Sub-module `irq_sync`: a parameterised-width two-flop synchronizer with async active-low clear, instantiated once with width 3.

## Test plan
- `mtvec`=0x8000_0000; exc_valid with code=2, pc=0x100, tval=0xDEAD; drain_ack tied high → cycle 2 mask={mepc,mcause,mtval,mstatus}; then mepc=0x100, mcause=2, mtval=0xDEAD, MIE=0, MPIE=old MIE, MPP=3; `redirect_pc`=0x8000_0000 at cycle 3.
- `mtvec`=0x8000_0001, MIE=1, `mie[7]`=1; pulse mtip, next_pc=0x200 → mip[7] set 3 cycles later; trap with mcause=0x8000…0007, mepc=0x200, mtval=0, `redirect_pc`=0x8000_001C.
- meip, msip and mtip all pending and enabled → mcause code 11. After MIE clears, no re-entry occurs until mret.
- mret with MPIE=1, mepc=0x300 → MIE=1, MPIE=1, MPP=0, `redirect_pc`=0x300, and only `mask.mstatus` set.
- drain_ack held low for 10 cycles, redirect_ready held low for 4 cycles → FSM stalls in DRAIN and REDIRECT; `redirect_pc` stays stable; `busy` high throughout.
- rst_n asserted during DRAIN → next cycle all outputs 0 and state IDLE; a new exception after release is handled normally.
